// File: rtl/fb_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : fb_arb_pkg
//  Purpose  : Shared types and helpers for the frame-buffer port arbiter:
//             grant encoding, write-buffer entry layout and a clog2 helper.
//  Revision : 1.0  initial release
// ============================================================================
package fb_arb_pkg;

  localparam int FB_AW = 16;
  localparam int FB_DW = 8;

  // Which requester owns the BRAM port in a given cycle
  typedef enum logic [1:0] {
    GNT_IDLE = 2'd0,
    GNT_RD   = 2'd1,
    GNT_WR   = 2'd2
  } grant_e;

  // One buffered pixel write at the default geometry
  typedef struct packed {
    logic [FB_AW-1:0] addr;
    logic [FB_DW-1:0] data;
  } wr_entry_t;

  // Ceiling log2; returns 0 for values <= 1
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fb_wr_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : fb_wr_fifo
//  Purpose  : Small synchronous FIFO of pending pixel writes with a
//             first-word fall-through head and a registered occupancy.
//  Revision : 1.0  initial release
// ============================================================================
module fb_wr_fifo
  import fb_arb_pkg::*;
#(
  parameter int  DEPTH   = 4,
  parameter type entry_t = wr_entry_t
) (
  input  logic                      clk_sys,
  input  logic                      reset,
  input  logic                      push,
  input  entry_t                    push_data,
  input  logic                      pop,
  output entry_t                    head,
  output logic [clog2(DEPTH):0]     level,
  output logic                      full,
  output logic                      empty
);

  localparam int PW = clog2(DEPTH);
  localparam int LW = PW + 1;

  entry_t        mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  // A full FIFO refuses pushes even when the head retires in the same cycle
  assign full    = (level == LW'(DEPTH));
  assign empty   = (level == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = mem[rd_ptr];

  // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  // Entry storage; contents need no reset since level gates visibility
  always_ff @(posedge clk_sys) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule
`default_nettype wire

// File: rtl/fb_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : fb_port_arbiter
//  Purpose  : Shares one single-port frame-buffer BRAM between the pixel
//             writer (buffered) and the scan-out reader. Reads win by
//             default; buffered writes are forced when the buffer is nearly
//             full or a write has waited MAX_WAIT lost cycles.
//  Revision : 1.0  initial release
// ============================================================================
module fb_port_arbiter
  import fb_arb_pkg::*;
#(
  parameter int AW         = FB_AW,
  parameter int DW         = FB_DW,
  parameter int WBUF_DEPTH = 4,
  parameter int RD_LAT     = 1,
  parameter int MAX_WAIT   = 8
) (
  input  logic                        clk_sys,
  input  logic                        reset,
  input  logic                        wr_valid,
  output logic                        wr_ready,
  input  logic [AW-1:0]               wr_addr,
  input  logic [DW-1:0]               wr_data,
  input  logic                        rd_req,
  output logic                        rd_ready,
  input  logic [AW-1:0]               rd_addr,
  output logic                        rd_valid,
  output logic [DW-1:0]               rd_data,
  output logic [AW-1:0]               ram_addr,
  output logic                        ram_we,
  output logic [DW-1:0]               ram_wdata,
  input  logic [DW-1:0]               ram_rdata,
  output logic [clog2(WBUF_DEPTH):0]  wr_level
);

  localparam int LW = clog2(WBUF_DEPTH) + 1;
  localparam int SW = clog2(MAX_WAIT + 1);

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } entry_t;

  entry_t              push_entry;
  entry_t              head;
  logic                fifo_full;
  logic                fifo_empty;
  logic                force_wr;
  grant_e              grant;
  logic [SW-1:0]       starve;
  logic [AW-1:0]       addr_q;
  logic [DW-1:0]       wdata_q;
  logic [RD_LAT-1:0]   rd_pipe;

  assign push_entry = '{addr: wr_addr, data: wr_data};
  assign wr_ready   = ~reset & ~fifo_full;

  fb_wr_fifo #(
    .DEPTH   (WBUF_DEPTH),
    .entry_t (entry_t)
  ) u_wr_fifo (
    .clk_sys   (clk_sys),
    .reset     (reset),
    .push      (wr_valid & wr_ready),
    .push_data (push_entry),
    .pop       (grant == GNT_WR),
    .head      (head),
    .level     (wr_level),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Writes jump the queue only when the buffer is one short of full or starved
  assign force_wr = (wr_level >= LW'(WBUF_DEPTH - 1)) | (starve == SW'(MAX_WAIT));

  // Grant selection uses only rd_req and registered state, never wr_valid
  always_comb begin
    grant = GNT_IDLE;
    if (!reset) begin
      if (!fifo_empty && (!rd_req || force_wr)) begin
        grant = GNT_WR;
      end else if (rd_req) begin
        grant = GNT_RD;
      end
    end
  end

  assign rd_ready = (grant == GNT_RD);

  // BRAM port mux; idle cycles hold the previous address and write data
  always_comb begin
    ram_addr  = addr_q;
    ram_wdata = wdata_q;
    ram_we    = 1'b0;
    if (reset) begin
      ram_addr  = '0;
      ram_wdata = '0;
    end else begin
      case (grant)
        GNT_RD: ram_addr = rd_addr;
        GNT_WR: begin
          ram_addr  = head.addr;
          ram_wdata = head.data;
          ram_we    = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Remember the last driven BRAM address/data so idle cycles can hold them
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      addr_q  <= ram_addr;
      wdata_q <= ram_wdata;
    end
  end

  // Count cycles a buffered write loses to reads, saturating at MAX_WAIT
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      starve <= '0;
    end else if (fifo_empty || grant == GNT_WR) begin
      starve <= '0;
    end else if (grant == GNT_RD && starve != SW'(MAX_WAIT)) begin
      starve <= starve + 1'b1;
    end
  end

  // Read-grant delay line matching the BRAM read latency
  generate
    if (RD_LAT == 1) begin : g_lat1
      // Single-stage delay of the read grant
      always_ff @(posedge clk_sys) begin
        if (reset) rd_pipe <= '0;
        else       rd_pipe <= (grant == GNT_RD);
      end
    end else begin : g_latn
      // Multi-stage delay of the read grant
      always_ff @(posedge clk_sys) begin
        if (reset) rd_pipe <= '0;
        else       rd_pipe <= {rd_pipe[RD_LAT-2:0], (grant == GNT_RD)};
      end
    end
  endgenerate

  // Masked during reset so reads granted before reset never report valid
  assign rd_valid = rd_pipe[RD_LAT-1] & ~reset;
  assign rd_data  = ram_rdata;

endmodule
`default_nettype wire
